// File: rtl/code_loader_pkg.sv
// Shared constants for the code loader: frame sync byte, FSM state encodings
// and the running-checksum helper.
package code_loader_pkg;

   localparam logic [7:0] LOADER_SYNC = 8'hD1;

   typedef enum logic [2:0] {
      LD_IDLE    = 3'd0,
      LD_LEN_HI  = 3'd1,
      LD_LEN_LO  = 3'd2,
      LD_DATA_HI = 3'd3,
      LD_DATA_LO = 3'd4,
      LD_CHECK   = 3'd5,
      LD_RUN     = 3'd6,
      LD_ERROR   = 3'd7
   } ld_state_e;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
      return acc + data;
   endfunction

endpackage

// File: rtl/code_loader_if.sv
// Byte-stream handshake from the host-link receiver plus the code-memory
// write port; master is the link/memory side, slave is the loader.
interface code_loader_if #(
   parameter int ADDR_W = 9
) ();

   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              code_w_en;
   logic [ADDR_W-1:0] code_addr_in;
   logic [15:0]       code_in;

   modport master (
      output byte_in,
      output byte_valid,
      input  byte_ready,
      input  code_w_en,
      input  code_addr_in,
      input  code_in
   );

   modport slave (
      input  byte_in,
      input  byte_valid,
      output byte_ready,
      output code_w_en,
      output code_addr_in,
      output code_in
   );

endinterface

// File: rtl/code_loader_load_timer.sv
// Clearable idle counter; expired flags the cycle in which the
// TIMEOUT_CYCLES-th consecutive idle cycle is being counted.
module load_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_r;

   // Idle-cycle counter: clear wins over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (inc) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = inc && (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/code_loader.sv
// Framed byte-stream code loader: assembles big-endian words, writes code
// memory, verifies the checksum and releases the core on success.
module code_loader
   import code_loader_pkg::*;
#(
   parameter int ADDR_W         = 9,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         rst,
   code_loader_if.slave bus,
   output logic         run,
   output logic         core_rst,
   output logic         load_err
);

   localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

   ld_state_e         state_r, state_s;
   logic [7:0]        len_hi_r, len_hi_s;
   logic [15:0]       len_r, len_s;
   logic [15:0]       word_cnt_r, word_cnt_s;
   logic [7:0]        csum_r, csum_s;
   logic [7:0]        hi_r, hi_s;
   logic              byte_ready_r, byte_ready_s;
   logic              code_w_en_r, code_w_en_s;
   logic [ADDR_W-1:0] code_addr_r, code_addr_s;
   logic [15:0]       code_in_r, code_in_s;
   logic              run_r, run_s;
   logic              core_rst_r, core_rst_s;
   logic              load_err_r, load_err_s;

   logic              xfer_s;
   logic              timed_s;
   logic              timer_expired_s;
   logic [15:0]       len_full_s;
   logic [15:0]       word_next_s;

   assign xfer_s      = bus.byte_valid & byte_ready_r;
   assign timed_s     = (state_r == LD_LEN_HI) || (state_r == LD_LEN_LO) ||
                        (state_r == LD_DATA_HI) || (state_r == LD_DATA_LO) ||
                        (state_r == LD_CHECK);
   assign len_full_s  = {len_hi_r, bus.byte_in};
   assign word_next_s = word_cnt_r + 16'd1;

   load_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_load_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (~timed_s | xfer_s),
      .inc     (timed_s & ~xfer_s),
      .expired (timer_expired_s)
   );

   // Next-state and next-output logic; expiry only fires on non-transfer cycles.
   always_comb begin
      state_s      = state_r;
      len_hi_s     = len_hi_r;
      len_s        = len_r;
      word_cnt_s   = word_cnt_r;
      csum_s       = csum_r;
      hi_s         = hi_r;
      byte_ready_s = 1'b1;
      code_w_en_s  = 1'b0;
      code_addr_s  = code_addr_r;
      code_in_s    = code_in_r;
      run_s        = run_r;
      core_rst_s   = core_rst_r;
      load_err_s   = load_err_r;

      if (timer_expired_s) begin
         state_s    = LD_ERROR;
         load_err_s = 1'b1;
         run_s      = 1'b0;
         core_rst_s = 1'b1;
      end else begin
         case (state_r)
            LD_IDLE, LD_RUN, LD_ERROR: begin
               if (xfer_s && (bus.byte_in == LOADER_SYNC)) begin
                  state_s     = LD_LEN_HI;
                  load_err_s  = 1'b0;
                  csum_s      = 8'h00;
                  word_cnt_s  = 16'd0;
                  code_addr_s = '0;
                  run_s       = 1'b0;
                  core_rst_s  = 1'b1;
               end else begin
                  state_s = state_r;
               end
            end
            LD_LEN_HI: begin
               if (xfer_s) begin
                  len_hi_s = bus.byte_in;
                  state_s  = LD_LEN_LO;
               end else begin
                  state_s = state_r;
               end
            end
            LD_LEN_LO: begin
               if (xfer_s) begin
                  len_s = len_full_s;
                  if ((len_full_s == 16'd0) || ({1'b0, len_full_s} > MAX_WORDS)) begin
                     state_s    = LD_ERROR;
                     load_err_s = 1'b1;
                  end else begin
                     state_s = LD_DATA_HI;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            LD_DATA_HI: begin
               if (xfer_s) begin
                  hi_s    = bus.byte_in;
                  csum_s  = csum_add(csum_r, bus.byte_in);
                  state_s = LD_DATA_LO;
               end else begin
                  state_s = state_r;
               end
            end
            LD_DATA_LO: begin
               if (xfer_s) begin
                  code_w_en_s = 1'b1;
                  code_in_s   = {hi_r, bus.byte_in};
                  code_addr_s = word_cnt_r[ADDR_W-1:0];
                  csum_s      = csum_add(csum_r, bus.byte_in);
                  word_cnt_s  = word_next_s;
                  if (word_next_s == len_r) begin
                     state_s = LD_CHECK;
                  end else begin
                     state_s = LD_DATA_HI;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            LD_CHECK: begin
               if (xfer_s) begin
                  if (bus.byte_in == csum_r) begin
                     state_s    = LD_RUN;
                     run_s      = 1'b1;
                     core_rst_s = 1'b0;
                  end else begin
                     state_s    = LD_ERROR;
                     load_err_s = 1'b1;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            default: begin
               state_s = LD_IDLE;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= LD_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Frame bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_hi_r     <= 8'h00;
         len_r        <= 16'd0;
         word_cnt_r   <= 16'd0;
         csum_r       <= 8'h00;
         hi_r         <= 8'h00;
         byte_ready_r <= 1'b0;
         code_w_en_r  <= 1'b0;
         code_addr_r  <= '0;
         code_in_r    <= 16'h0000;
         run_r        <= 1'b0;
         core_rst_r   <= 1'b1;
         load_err_r   <= 1'b0;
      end else begin
         len_hi_r     <= len_hi_s;
         len_r        <= len_s;
         word_cnt_r   <= word_cnt_s;
         csum_r       <= csum_s;
         hi_r         <= hi_s;
         byte_ready_r <= byte_ready_s;
         code_w_en_r  <= code_w_en_s;
         code_addr_r  <= code_addr_s;
         code_in_r    <= code_in_s;
         run_r        <= run_s;
         core_rst_r   <= core_rst_s;
         load_err_r   <= load_err_s;
      end
   end

   assign bus.byte_ready   = byte_ready_r;
   assign bus.code_w_en    = code_w_en_r;
   assign bus.code_addr_in = code_addr_r;
   assign bus.code_in      = code_in_r;
   assign run              = run_r;
   assign core_rst         = core_rst_r;
   assign load_err         = load_err_r;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: directed scenarios plus randomized
// frames scored against a frame-level reference model.
module tb_code_loader;
   import code_loader_pkg::*;

   localparam int ADDR_W = 9;
   localparam int TMO    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run, core_rst, load_err;

   int checks   = 0;
   int failures = 0;

   logic [24:0] got_q[$];
   logic [24:0] exp_q[$];
   logic [7:0]  fr_q[$];
   logic        exp_run;
   logic        exp_err;

   code_loader_if #(.ADDR_W(ADDR_W)) bus ();

   code_loader #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .run      (run),
      .core_rst (core_rst),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   // Record every memory write seen mid-cycle.
   always @(negedge clk) begin
      if (bus.code_w_en === 1'b1) got_q.push_back({bus.code_addr_in, bus.code_in});
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap);
      foreach (fr_q[i]) begin
         send_byte(fr_q[i]);
         if (max_gap > 0) idle($urandom_range(max_gap, 0));
      end
   endtask

   // Builds a frame of len words; corrupt != 0 perturbs the checksum.
   task automatic make_frame(input int len, input logic [7:0] corrupt);
      int sum = 0;
      logic [7:0] b;
      fr_q.delete();
      fr_q.push_back(8'hD1);
      fr_q.push_back(len[15:8]);
      fr_q.push_back(len[7:0]);
      if (len == 0 || len > 512) return;
      for (int i = 0; i < 2 * len; i++) begin
         b = ($urandom_range(7, 0) == 0) ? 8'hD1 : 8'($urandom_range(255, 0));
         fr_q.push_back(b);
         sum += int'(b);
      end
      fr_q.push_back(8'(sum % 256) + corrupt);
   endtask

   // Reference model: what a complete frame should write and its final status.
   function automatic void model();
      int len;
      int sum = 0;
      exp_q.delete();
      len = int'({fr_q[1], fr_q[2]});
      if (len == 0 || len > 512) begin
         exp_err = 1'b1;
         exp_run = 1'b0;
         return;
      end
      for (int i = 0; i < len; i++) begin
         exp_q.push_back({ADDR_W'(i), fr_q[3 + 2 * i], fr_q[4 + 2 * i]});
         sum += int'(fr_q[3 + 2 * i]) + int'(fr_q[4 + 2 * i]);
      end
      exp_run = (int'(fr_q[3 + 2 * len]) == sum % 256);
      exp_err = !exp_run;
   endfunction

   task automatic test_reset();
      #3 rst = 1'b0;
      #1;
      checks += 7;
      if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.byte_ready); end
      if (bus.code_w_en !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.code_w_en); end
      if (bus.code_addr_in !== 9'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.code_addr_in); end
      if (bus.code_in !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.code_in); end
      if (run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", run); end
      if (core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
      if (load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
      idle(2);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", bus.byte_ready); end
      idle(1);
      checks++;
      if (bus.byte_ready !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b exp=1", bus.byte_ready); end
   endtask

   task automatic test_nominal();
      logic [7:0] bytes [8] = '{8'hD1, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
      got_q.delete();
      for (int i = 0; i < 7; i++) send_byte(bytes[i]);
      checks += 2;
      if (run !== 1'b0) begin failures++; $display("FAIL nom_run_early got=%b exp=0", run); end
      if (core_rst !== 1'b1) begin failures++; $display("FAIL nom_core_rst_early got=%b exp=1", core_rst); end
      send_byte(bytes[7]);
      checks += 4;
      if (run !== 1'b1) begin failures++; $display("FAIL nom_run got=%b exp=1", run); end
      if (core_rst !== 1'b0) begin failures++; $display("FAIL nom_core_rst got=%b exp=0", core_rst); end
      if (load_err !== 1'b0) begin failures++; $display("FAIL nom_load_err got=%b exp=0", load_err); end
      if (got_q.size() !== 2) begin failures++; $display("FAIL nom_wr_count got=%0d exp=2", got_q.size()); end
      else begin
         checks += 2;
         if (got_q[0] !== {9'd0, 16'h1234}) begin failures++; $display("FAIL nom_wr0 got=%h exp=%h", got_q[0], {9'd0, 16'h1234}); end
         if (got_q[1] !== {9'd1, 16'hABCD}) begin failures++; $display("FAIL nom_wr1 got=%h exp=%h", got_q[1], {9'd1, 16'hABCD}); end
      end
   endtask

   task automatic test_zero_len();
      got_q.delete();
      send_byte(8'hD1); send_byte(8'h00); send_byte(8'h00);
      idle(2);
      checks += 4;
      if (load_err !== 1'b1) begin failures++; $display("FAIL zlen_load_err got=%b exp=1", load_err); end
      if (run !== 1'b0) begin failures++; $display("FAIL zlen_run got=%b exp=0", run); end
      if (core_rst !== 1'b1) begin failures++; $display("FAIL zlen_core_rst got=%b exp=1", core_rst); end
      if (got_q.size() !== 0) begin failures++; $display("FAIL zlen_writes got=%0d exp=0", got_q.size()); end
   endtask

   task automatic test_bad_csum();
      logic [7:0] bytes [8] = '{8'hD1, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
      got_q.delete();
      for (int i = 0; i < 8; i++) send_byte(bytes[i]);
      idle(1);
      checks += 4;
      if (load_err !== 1'b1) begin failures++; $display("FAIL bad_load_err got=%b exp=1", load_err); end
      if (run !== 1'b0) begin failures++; $display("FAIL bad_run got=%b exp=0", run); end
      if (core_rst !== 1'b1) begin failures++; $display("FAIL bad_core_rst got=%b exp=1", core_rst); end
      if (got_q.size() !== 2) begin failures++; $display("FAIL bad_writes got=%0d exp=2", got_q.size()); end
   endtask

   task automatic test_timeout();
      got_q.delete();
      send_byte(8'hD1); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
      idle(TMO - 1);
      checks++;
      if (load_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", load_err); end
      idle(1);
      checks += 4;
      if (load_err !== 1'b1) begin failures++; $display("FAIL tmo_load_err got=%b exp=1", load_err); end
      if (run !== 1'b0) begin failures++; $display("FAIL tmo_run got=%b exp=0", run); end
      if (core_rst !== 1'b1) begin failures++; $display("FAIL tmo_core_rst got=%b exp=1", core_rst); end
      if (got_q.size() !== 0) begin failures++; $display("FAIL tmo_writes got=%0d exp=0", got_q.size()); end
   endtask

   task automatic test_reload();
      logic [7:0] bytes [6] = '{8'hD1, 8'h00, 8'h01, 8'h00, 8'h05, 8'h05};
      test_nominal();
      got_q.delete();
      send_byte(bytes[0]);
      checks += 2;
      if (run !== 1'b0) begin failures++; $display("FAIL reload_run_drop got=%b exp=0", run); end
      if (core_rst !== 1'b1) begin failures++; $display("FAIL reload_core_rst got=%b exp=1", core_rst); end
      for (int i = 1; i < 6; i++) send_byte(bytes[i]);
      checks += 3;
      if (run !== 1'b1) begin failures++; $display("FAIL reload_run got=%b exp=1", run); end
      if (got_q.size() !== 1) begin failures++; $display("FAIL reload_writes got=%0d exp=1", got_q.size()); end
      else if (got_q[0] !== {9'd0, 16'h0005}) begin failures++; $display("FAIL reload_wr0 got=%h exp=%h", got_q[0], {9'd0, 16'h0005}); end
   endtask

   task automatic test_midframe_reset();
      send_byte(8'hD1); send_byte(8'h00); send_byte(8'h03); send_byte(8'hAA);
      rst = 1'b0;
      #1;
      checks += 6;
      if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL mrst_ready got=%b exp=0", bus.byte_ready); end
      if (bus.code_w_en !== 1'b0) begin failures++; $display("FAIL mrst_wen got=%b exp=0", bus.code_w_en); end
      if (bus.code_in !== 16'h0000) begin failures++; $display("FAIL mrst_data got=%h exp=0", bus.code_in); end
      if (run !== 1'b0) begin failures++; $display("FAIL mrst_run got=%b exp=0", run); end
      if (core_rst !== 1'b1) begin failures++; $display("FAIL mrst_core_rst got=%b exp=1", core_rst); end
      if (load_err !== 1'b0) begin failures++; $display("FAIL mrst_load_err got=%b exp=0", load_err); end
      idle(2);
      rst = 1'b1;
      idle(1);
      test_nominal();
   endtask

   task automatic test_random();
      logic [7:0] junk;
      for (int f = 0; f < 24; f++) begin
         got_q.delete();
         repeat ($urandom_range(3, 0)) begin
            junk = 8'($urandom_range(255, 0));
            send_byte((junk == LOADER_SYNC) ? 8'h00 : junk);
         end
         case ($urandom_range(9, 0))
            0: make_frame(0, 8'h00);
            1: make_frame(513 + $urandom_range(100, 0), 8'h00);
            2, 3: make_frame($urandom_range(6, 1), 8'($urandom_range(255, 1)));
            default: make_frame($urandom_range(6, 1), 8'h00);
         endcase
         model();
         send_frame(3);
         idle(2);
         checks += 4;
         if (run !== exp_run) begin failures++; $display("FAIL rnd_run frame=%0d got=%b exp=%b", f, run, exp_run); end
         if (load_err !== exp_err) begin failures++; $display("FAIL rnd_load_err frame=%0d got=%b exp=%b", f, load_err, exp_err); end
         if (core_rst !== !exp_run) begin failures++; $display("FAIL rnd_core_rst frame=%0d got=%b exp=%b", f, core_rst, !exp_run); end
         if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rnd_wr_count frame=%0d got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
         else begin
            foreach (exp_q[i]) begin
               checks++;
               if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_wr frame=%0d idx=%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
            end
         end
      end
   endtask

   task automatic test_max_len();
      got_q.delete();
      make_frame(512, 8'h00);
      model();
      send_frame(0);
      idle(2);
      checks += 3;
      if (run !== 1'b1) begin failures++; $display("FAIL max_run got=%b exp=1", run); end
      if (got_q.size() !== 512) begin failures++; $display("FAIL max_wr_count got=%0d exp=512", got_q.size()); end
      else if (got_q[511] !== exp_q[511]) begin failures++; $display("FAIL max_last_wr got=%h exp=%h", got_q[511], exp_q[511]); end
      if (got_q.size() > 0 && got_q[got_q.size() - 1][24:16] !== 9'd511) begin failures++; $display("FAIL max_last_addr got=%0d exp=511", got_q[got_q.size() - 1][24:16]); end
      got_q.delete();
      make_frame(513, 8'h00);
      send_frame(0);
      idle(2);
      checks += 3;
      if (load_err !== 1'b1) begin failures++; $display("FAIL over_load_err got=%b exp=1", load_err); end
      if (run !== 1'b0) begin failures++; $display("FAIL over_run got=%b exp=0", run); end
      if (got_q.size() !== 0) begin failures++; $display("FAIL over_writes got=%0d exp=0", got_q.size()); end
   endtask

   initial begin
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      test_reset();
      test_nominal();
      test_zero_len();
      test_bad_csum();
      test_timeout();
      test_reload();
      test_midframe_reset();
      test_random();
      test_max_len();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
